dffs: RTL and testbench

DFFS -- requirements
Module: dffs

---
 rtl/dffs_pkg.sv | 10 +
 rtl/dff_bit.sv | 21 ++
 rtl/dffs.sv | 43 ++++
 tb/tb_dffs.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dffs_pkg.sv
// Shared constants for the dffs register slice: legal width range and
// reset synchronizer depth.
package dffs_pkg;

  localparam int unsigned DFFS_SIZE_MIN = 1;
  localparam int unsigned DFFS_SIZE_MAX = 64;
  // Two flops between the raw reset pin and the data flops.
  localparam int unsigned SYNC_STAGES   = 2;

endpackage : dffs_pkg

// File: rtl/dff_bit.sv
// One-bit D flop with asynchronous active-low reset and a per-bit reset value.
module dff_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic q_q;

  // Capture d on every rising edge; reset forces the configured value at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= RST_VAL;
    else         q_q <= d_i;
  end

  assign q_o = q_q;

endmodule : dff_bit

// File: rtl/dffs.sv
// SIZE-bit register built from dff_bit slices. The raw reset asserts
// asynchronously but its release is retimed through a two-flop synchronizer,
// so the data flops leave reset cleanly on a clock edge.
module dffs
  import dffs_pkg::*;
#(
  parameter int unsigned     SIZE    = 5,
  parameter logic [SIZE-1:0] RST_VAL = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [SIZE-1:0] write_i,
  output logic [SIZE-1:0] read_o
);

  if (SIZE < DFFS_SIZE_MIN || SIZE > DFFS_SIZE_MAX) begin : g_size_chk
    $error("dffs: SIZE must be in 1..64");
  end

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic                   rst_sync_n;

  // Reset synchronizer: clears instantly, shifts ones in after rst_i rises.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_sync_n = rst_sync_q[SYNC_STAGES-1];

  // One independent flop per bit; read_o comes straight from the flops.
  for (genvar k = 0; k < SIZE; k++) begin : g_bit
    dff_bit #(
      .RST_VAL (RST_VAL[k])
    ) u_bit (
      .clk_i  (clk_i),
      .rst_ni (rst_sync_n),
      .d_i    (write_i[k]),
      .q_o    (read_o[k])
    );
  end

endmodule : dffs

// File: tb/tb_dffs.sv
// Directed bench for dffs: three instances (SIZE 5, 1 and 64) share clock
// and reset; each task drives one scenario and checks inline.
module tb_dffs;

  logic        clk;
  logic        rst;
  logic [4:0]  w5, r5;
  logic        w1, r1;
  logic [63:0] w64, r64;
  int          checks;
  int          errors;

  localparam logic [63:0] ONES64 = {64{1'b1}};

  dffs #(.SIZE(5)) u_dut5 (
    .clk_i(clk), .rst_i(rst), .write_i(w5), .read_o(r5)
  );

  dffs #(.SIZE(1), .RST_VAL(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .write_i(w1), .read_o(r1)
  );

  dffs #(.SIZE(64), .RST_VAL({64{1'b1}})) u_dut64 (
    .clk_i(clk), .rst_i(rst), .write_i(w64), .read_o(r64)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reset asserted with a busy write bus: outputs at reset values at once
  // and edges ignored while rst stays low.
  task automatic test_reset();
    rst = 1'b1; w5 = 5'h00; w1 = 1'b0; w64 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    w5 = 5'h15; w1 = 1'b0; w64 = 64'h0123_4567_89ab_cdef;
    rst = 1'b0;
    #1;
    checks++; if (r5 !== 5'h00) begin errors++; $display("FAIL reset_async_5 got %h want %h", r5, 5'h00); end
    checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL reset_async_1 got %b want %b", r1, 1'b1); end
    checks++; if (r64 !== ONES64) begin errors++; $display("FAIL reset_async_64 got %h want %h", r64, ONES64); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (r5 !== 5'h00) begin errors++; $display("FAIL reset_hold_5 edge %0d got %h want %h", i, r5, 5'h00); end
      checks++; if (r64 !== ONES64) begin errors++; $display("FAIL reset_hold_64 edge %0d got %h want %h", i, r64, ONES64); end
    end
  endtask

  // Release latency: two edges to release, capture on the third.
  task automatic test_release();
    logic [63:0] v64;
    v64 = 64'hdead_beef_0000_0042;
    rst = 1'b1; w5 = 5'd9; w1 = 1'b0; w64 = v64;
    @(posedge clk); @(negedge clk);
    checks++; if (r5 !== 5'h00) begin errors++; $display("FAIL release_edge1_5 got %h want %h", r5, 5'h00); end
    checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL release_edge1_1 got %b want %b", r1, 1'b1); end
    @(posedge clk); @(negedge clk);
    checks++; if (r5 !== 5'h00) begin errors++; $display("FAIL release_edge2_5 got %h want %h", r5, 5'h00); end
    checks++; if (r64 !== ONES64) begin errors++; $display("FAIL release_edge2_64 got %h want %h", r64, ONES64); end
    @(posedge clk); @(negedge clk);
    checks++; if (r5 !== 5'd9) begin errors++; $display("FAIL release_edge3_5 got %h want %h", r5, 5'd9); end
    checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL release_edge3_1 got %b want %b", r1, 1'b0); end
    checks++; if (r64 !== v64) begin errors++; $display("FAIL release_edge3_64 got %h want %h", r64, v64); end
  endtask

  // One-cycle reset pulse then external +1 feedback driven 5 ns after each
  // edge: 0..31 then wrap to 0, 9 more.
  task automatic test_count();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #5 w5 = r5 + 5'd1;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      checks++; if (r5 !== 5'(i)) begin errors++; $display("FAIL count step %0d got %0d want %0d", i, r5, 5'(i)); end
      @(posedge clk);
      #5 w5 = r5 + 5'd1;
    end
  endtask

  // Hold 7, then drop reset midway between edges: cleared before next edge,
  // stays cleared across two edges, then release again.
  task automatic test_midreset();
    @(negedge clk);
    w5 = 5'd7;
    @(posedge clk); @(negedge clk);
    checks++; if (r5 !== 5'd7) begin errors++; $display("FAIL midreset_pre got %0d want %0d", r5, 5'd7); end
    #5 rst = 1'b0;
    #1;
    checks++; if (r5 !== 5'd0) begin errors++; $display("FAIL midreset_async got %0d want %0d", r5, 5'd0); end
    checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL midreset_async_1 got %b want %b", r1, 1'b1); end
    checks++; if (r64 !== ONES64) begin errors++; $display("FAIL midreset_async_64 got %h want %h", r64, ONES64); end
    w5 = 5'h1f;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (r5 !== 5'd0) begin errors++; $display("FAIL midreset_hold edge %0d got %0d want %0d", i, r5, 5'd0); end
    end
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
  endtask

  // Glitchy write bus: changes just after an edge are not captured, read
  // stays stable mid-cycle, final value at the edge is what lands.
  task automatic test_glitch();
    #5 w5 = 5'h03;
    @(posedge clk);
    #1 w5 = 5'h0a;
    #1;
    checks++; if (r5 !== 5'h03) begin errors++; $display("FAIL glitch_hold_after_edge got %h want %h", r5, 5'h03); end
    #3 w5 = 5'h1f;
    #3 w5 = 5'h00;
    @(negedge clk);
    checks++; if (r5 !== 5'h03) begin errors++; $display("FAIL glitch_stable_mid got %h want %h", r5, 5'h03); end
    #2 w5 = 5'h0e;
    #3 w5 = 5'b10101;
    @(posedge clk);
    #1 w5 = 5'h00;
    @(negedge clk);
    checks++; if (r5 !== 5'b10101) begin errors++; $display("FAIL glitch_capture got %b want %b", r5, 5'b10101); end
    @(posedge clk); @(negedge clk);
    checks++; if (r5 !== 5'h00) begin errors++; $display("FAIL glitch_next got %b want %b", r5, 5'h00); end
  endtask

  // Walking one on the 64-bit and 1-bit instances, plus all-ones on both:
  // output lags input by exactly one edge.
  task automatic test_walk();
    logic [63:0] e64, p64;
    logic        e1,  p1;
    @(negedge clk);
    p64 = w64; p1 = w1;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i <= 64; i++) begin
      e64 = (i == 64) ? ONES64 : (64'd1 << i);
      e1  = (i % 2 == 0) ? 1'b1 : 1'b0;
      w64 = e64; w1 = e1;
      #1;
      checks++; if (r64 !== p64) begin errors++; $display("FAIL walk64_lag step %0d got %h want %h", i, r64, p64); end
      checks++; if (r1 !== p1) begin errors++; $display("FAIL walk1_lag step %0d got %b want %b", i, r1, p1); end
      @(posedge clk); @(negedge clk);
      checks++; if (r64 !== e64) begin errors++; $display("FAIL walk64 step %0d got %h want %h", i, r64, e64); end
      checks++; if (r1 !== e1) begin errors++; $display("FAIL walk1 step %0d got %b want %b", i, r1, e1); end
      p64 = e64; p1 = e1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_release();
    test_count();
    test_midreset();
    test_glitch();
    test_walk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dffs
